// File: rtl/lsu_multi_width_pkg.sv
// ---------------------------------------------------------------------------
// lsu_multi_width_pkg
// Shared types and helpers for the multi-width load/store unit.
//   load_store_func_code : LB LH LW LBU LHU SB SH SW
//   lsu_state_e          : IDLE, REQ, WAIT_RVALID
//   lsu_size_e           : access size decoded from the operator
//   lsu_size / lsu_is_store / lsu_is_signed / lsu_misaligned / lsu_be
// No ports (package).
// ---------------------------------------------------------------------------
package lsu_multi_width_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } load_store_func_code;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ         = 2'd1,
    WAIT_RVALID = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } lsu_size_e;

  function automatic lsu_size_e lsu_size(input load_store_func_code op);
    lsu_size_e sz;
    case (op)
      LB, LBU, SB: sz = SIZE_B;
      LH, LHU, SH: sz = SIZE_H;
      default:     sz = SIZE_W;
    endcase
    return sz;
  endfunction

  function automatic logic lsu_is_store(input load_store_func_code op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // LW sign-extends too: it only matters when the bus is wider than 32 bits.
  function automatic logic lsu_is_signed(input load_store_func_code op);
    return (op == LB) || (op == LH) || (op == LW);
  endfunction

  function automatic logic lsu_misaligned(input load_store_func_code op,
                                          input logic [2:0]          off);
    logic bad;
    case (lsu_size(op))
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = (off[1:0] != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Byte enables for an access of the operator's size at lane offset off,
  // clipped to be_w lanes. Result is 8 bits wide; callers keep be_w LSBs.
  function automatic logic [7:0] lsu_be(input load_store_func_code op,
                                        input logic [2:0]          off,
                                        input int unsigned         be_w);
    logic [7:0] base;
    logic [8:0] lane_mask;
    case (lsu_size(op))
      SIZE_B:  base = 8'h01;
      SIZE_H:  base = 8'h03;
      default: base = 8'h0F;
    endcase
    lane_mask = (9'h001 << be_w) - 9'h001;
    return (base << off) & lane_mask[7:0];
  endfunction

endpackage

// File: rtl/lsu_multi_width_if.sv
// ---------------------------------------------------------------------------
// lsu_multi_width_if
// Data-memory bus between the LSU and data memory (req/gnt/rvalid protocol).
//   master modport (LSU side)   : drives req, addr, we, be, wdata;
//                                 receives gnt, rvalid, rdata
//   slave  modport (memory side): the mirror image
// Parameters: DATA_W (32/64), ADDR_W. Byte-enable width is DATA_W/8.
// ---------------------------------------------------------------------------
interface lsu_multi_width_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              data_req_op;
  logic              data_gnt_i;
  logic [ADDR_W-1:0] data_addr_op;
  logic              data_we_op;
  logic [BE_W-1:0]   data_be_op;
  logic [DATA_W-1:0] data_wdata_op;
  logic              data_rvalid_i;
  logic [DATA_W-1:0] data_rdata_i;

  modport master (
    output data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/lsu_multi_width_load_align.sv
// ---------------------------------------------------------------------------
// lsu_multi_width_load_align
// Combinational load formatter: shifts the addressed lane down to bit 0 and
// sign- or zero-extends it to DATA_W according to the load operator.
//   rdata_i  in  DATA_W  raw read data from memory
//   off_i    in  OFF_W   byte offset of the access within the bus word
//   op_i     in  enum    load operator (LB LH LW LBU LHU)
//   result_o out DATA_W  aligned, extended load value
// ---------------------------------------------------------------------------
module lsu_multi_width_load_align
  import lsu_multi_width_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [OFF_W-1:0]  off_i,
  input  load_store_func_code op_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] keep_mask;
  logic [5:0]        nbits;
  logic              fill;

  assign lane = rdata_i >> {off_i, 3'b000};

  always_comb begin
    case (lsu_size(op_i))
      SIZE_B:  nbits = 6'd8;
      SIZE_H:  nbits = 6'd16;
      default: nbits = 6'd32;
    endcase
    // Shifting all-ones by >= DATA_W yields zero, so a 32-bit load on a
    // 32-bit bus naturally keeps every bit.
    keep_mask = ~({DATA_W{1'b1}} << nbits);
    fill      = lsu_is_signed(op_i) & lane[nbits - 6'd1];
    result_o  = (lane & keep_mask) | ({DATA_W{fill}} & ~keep_mask);
  end

endmodule

// File: rtl/lsu_multi_width.sv
// ---------------------------------------------------------------------------
// lsu_multi_width
// Multi-width load/store unit: byte/half/word loads (signed and unsigned) and
// stores over a registered req/gnt/rvalid data-memory handshake, with
// misaligned-access rejection.
// Optional feature macro: LSU_TIMEOUT_EN -- adds a transaction watchdog that
// aborts after TIMEOUT_CYCLES cycles in REQ/WAIT_RVALID.
// Ports:
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   lsu_en_ip        in   current op is a memory op
//   lsu_operator_ip  in   load_store_func_code
//   alu_valid_ip     in   address from ALU valid
//   mem_addr_ip      in   byte address
//   lsu_wdata_ip     in   right-aligned store data
//   mem              if   data-memory bus (master modport)
//   load_mem_data_op out  aligned/extended load result (held until next load)
//   lsu_rvalid_op    out  1-cycle pulse: load data valid / store done
//   lsu_busy_op      out  LSU not idle
//   misalign_err_op  out  1-cycle pulse: misaligned op rejected
//   timeout_err_op   out  1-cycle pulse: transaction aborted (0 without macro)
// ---------------------------------------------------------------------------
module lsu_multi_width
  import lsu_multi_width_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lsu_en_ip,
  input  load_store_func_code lsu_operator_ip,
  input  logic                alu_valid_ip,
  input  logic [ADDR_W-1:0]   mem_addr_ip,
  input  logic [DATA_W-1:0]   lsu_wdata_ip,
  lsu_multi_width_if.master   mem,
  output logic [DATA_W-1:0]   load_mem_data_op,
  output logic                lsu_rvalid_op,
  output logic                lsu_busy_op,
  output logic                misalign_err_op,
  output logic                timeout_err_op
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("lsu_multi_width: DATA_W must be 32 or 64 and TIMEOUT_CYCLES >= 1");
  end

  lsu_state_e          state_q,     state_d;
  logic                req_q,       req_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic                we_q,        we_d;
  logic [BE_W-1:0]     be_q,        be_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  load_store_func_code op_q,        op_d;
  logic [OFF_W-1:0]    off_q,       off_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic                rvalid_q,    rvalid_d;
  logic                misalign_q,  misalign_d;
  logic                timeout_q,   timeout_d;

  logic [OFF_W-1:0]  off_in;
  logic [7:0]        be_full;
  logic [DATA_W-1:0] load_aligned;
  logic              timeout_hit;

  assign off_in  = mem_addr_ip[OFF_W-1:0];
  assign be_full = lsu_be(lsu_operator_ip, 3'(off_in), BE_W);

  // Lane extraction uses the offset/op captured at accept, so it stays
  // correct regardless of what decode presents while we wait for rvalid.
  lsu_multi_width_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .rdata_i  (mem.data_rdata_i),
    .off_i    (off_q),
    .op_i     (op_q),
    .result_o (load_aligned)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // cnt_q holds the number of busy cycles already completed, so this fires
  // during the TIMEOUT_CYCLES-th cycle spent in REQ/WAIT_RVALID.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    rvalid_d    = 1'b0;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (lsu_en_ip && alu_valid_ip) begin
          if (lsu_misaligned(lsu_operator_ip, 3'(off_in))) begin
            misalign_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = {mem_addr_ip[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            we_d    = lsu_is_store(lsu_operator_ip);
            be_d    = be_full[BE_W-1:0];
            wdata_d = lsu_wdata_ip << {off_in, 3'b000};
            op_d    = lsu_operator_ip;
            off_d   = off_in;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      REQ: begin
`ifdef LSU_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // A grant in the same cycle as the watchdog expiry still completes.
        if (mem.data_gnt_i) begin
          req_d = 1'b0;
          if (we_q) begin
            rvalid_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = WAIT_RVALID;
          end
        end else if (timeout_hit) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end

      WAIT_RVALID: begin
`ifdef LSU_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (mem.data_rvalid_i) begin
          load_data_d = load_aligned;
          rvalid_d    = 1'b1;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      op_q        <= LB;
      off_q       <= '0;
      load_data_q <= '0;
      rvalid_q    <= 1'b0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
      rvalid_q    <= rvalid_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign mem.data_req_op   = req_q;
  assign mem.data_addr_op  = addr_q;
  assign mem.data_we_op    = we_q;
  assign mem.data_be_op    = be_q;
  assign mem.data_wdata_op = wdata_q;

  assign load_mem_data_op = load_data_q;
  assign lsu_rvalid_op    = rvalid_q;
  assign misalign_err_op  = misalign_q;
  assign timeout_err_op   = timeout_q;
  assign lsu_busy_op      = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_multi_width.sv
// ---------------------------------------------------------------------------
// tb_lsu_multi_width
// Directed bench for lsu_multi_width. Stimulus pushes the expected core-side
// event (and expected bus beat) into queues; monitors on the falling edge pop
// and compare whenever the DUT raises an event or a bus grant happens.
// ---------------------------------------------------------------------------
module tb_lsu_multi_width;
  import lsu_multi_width_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                en;
  logic                valid;
  load_store_func_code op;
  logic [AW-1:0]       addr;
  logic [DW-1:0]       wdata;
  logic [DW-1:0]       load_data;
  logic                rvalid, busy, misal, tmo;

  lsu_multi_width_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  lsu_multi_width #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lsu_en_ip        (en),
    .lsu_operator_ip  (op),
    .alu_valid_ip     (valid),
    .mem_addr_ip      (addr),
    .lsu_wdata_ip     (wdata),
    .mem              (bus),
    .load_mem_data_op (load_data),
    .lsu_rvalid_op    (rvalid),
    .lsu_busy_op      (busy),
    .misalign_err_op  (misal),
    .timeout_err_op   (tmo)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // evt encoding: {timeout, misalign, rvalid}
  typedef struct {
    logic [2:0]  evt;
    bit          is_load;
    logic [31:0] data;
    string       name;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    string       name;
  } beat_t;

  resp_t resp_q[$];
  beat_t beat_q[$];
  logic [31:0] last_load = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Core-side event monitor
  always @(negedge clk) begin : mon_resp
    resp_t r;
    logic [2:0] evt;
    if (rst_n) begin
      evt = {tmo, misal, rvalid};
      if (evt != 3'b000) begin
        if (resp_q.size() == 0) begin
          check("unexpected_event", {29'b0, evt}, 32'h0);
        end else begin
          r = resp_q.pop_front();
          check({r.name, "_evt"}, {29'b0, evt}, {29'b0, r.evt});
          if (r.is_load) check({r.name, "_data"}, load_data, r.data);
        end
      end
    end
  end

  // Bus beat monitor: compares the request fields on the granted cycle
  always @(negedge clk) begin : mon_bus
    beat_t b;
    if (rst_n && bus.data_req_op && bus.data_gnt_i) begin
      if (beat_q.size() == 0) begin
        check("unexpected_grant", 32'h1, 32'h0);
      end else begin
        b = beat_q.pop_front();
        check({b.name, "_addr"}, bus.data_addr_op, b.addr);
        check({b.name, "_we"}, {31'b0, bus.data_we_op}, {31'b0, b.we});
        check({b.name, "_be"}, {28'b0, bus.data_be_op}, {28'b0, b.be});
        if (b.we) check({b.name, "_wdata"}, bus.data_wdata_op, b.wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string name, input load_store_func_code o,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wdata, input logic [31:0] e_res);
    bit st;
    st = (o == SB) || (o == SH) || (o == SW);
    beat_q.push_back('{e_addr, st, e_be, e_wdata, name});
    resp_q.push_back('{3'b001, !st, e_res, name});
    en = 1'b1; valid = 1'b1; op = o; addr = a; wdata = wd;
    tick();
    en = 1'b0; valid = 1'b0;
    for (int i = 0; i < gnt_dly; i++) begin
      check({name, "_req_held"}, {31'b0, bus.data_req_op}, 32'h1);
      check({name, "_be_held"}, {28'b0, bus.data_be_op}, {28'b0, e_be});
      check({name, "_addr_held"}, bus.data_addr_op, e_addr);
      if (st) check({name, "_wdata_held"}, bus.data_wdata_op, e_wdata);
      // A misaligned op offered while busy must be ignored (no error pulse).
      en = 1'b1; valid = 1'b1; op = LW; addr = 32'h101;
      tick();
    end
    en = 1'b0; valid = 1'b0;
    bus.data_gnt_i = 1'b1;
    tick();
    bus.data_gnt_i = 1'b0;
    check({name, "_req_drop"}, {31'b0, bus.data_req_op}, 32'h0);
    if (!st) begin
      for (int i = 0; i < rv_dly; i++) begin
        check({name, "_busy_wait"}, {31'b0, busy}, 32'h1);
        tick();
      end
      bus.data_rvalid_i = 1'b1;
      bus.data_rdata_i  = rd;
      tick();
      bus.data_rvalid_i = 1'b0;
      bus.data_rdata_i  = 32'h5A5A5A5A;
      last_load = e_res;
    end
    check({name, "_busy_done"}, {31'b0, busy}, 32'h0);
    tick();
  endtask

  task automatic do_misal(input string name, input load_store_func_code o, input logic [31:0] a);
    resp_q.push_back('{3'b010, 1'b0, 32'h0, name});
    en = 1'b1; valid = 1'b1; op = o; addr = a; wdata = 32'h0;
    tick();
    en = 1'b0; valid = 1'b0;
    check({name, "_no_req"}, {31'b0, bus.data_req_op}, 32'h0);
    check({name, "_no_busy"}, {31'b0, busy}, 32'h0);
    tick();
  endtask

  initial begin
    en = 1'b0; valid = 1'b0; op = LW; addr = 32'h0; wdata = 32'h0;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = 32'h0;

    repeat (3) tick();
    check("rst_req",    {31'b0, bus.data_req_op}, 32'h0);
    check("rst_busy",   {31'b0, busy}, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_misal",  {31'b0, misal}, 32'h0);
    check("rst_tmo",    {31'b0, tmo}, 32'h0);
    check("rst_ldata",  load_data, 32'h0);
    check("rst_be",     {28'b0, bus.data_be_op}, 32'h0);
    rst_n = 1'b1;
    tick();

    //     name    op   addr       wdata        gnt rv rdata        e_addr     be    e_wdata      e_result
    do_op("lw",    LW,  32'h100, 32'h0,         0, 0, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF);
    do_op("lb",    LB,  32'h103, 32'h0,         0, 0, 32'h80FFFFFF, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80);
    do_op("lbu",   LBU, 32'h103, 32'h0,         0, 0, 32'h80FFFFFF, 32'h100, 4'h8, 32'h0,        32'h00000080);
    do_op("sh",    SH,  32'h102, 32'h0000ABCD,  3, 0, 32'h0,        32'h100, 4'hC, 32'hABCD0000, 32'h0);
    check("sh_ldata_hold", load_data, last_load);
    do_misal("lw_mis", LW, 32'h101);
    do_op("lh",    LH,  32'h102, 32'h0,         0, 0, 32'h80011234, 32'h100, 4'hC, 32'h0,        32'hFFFF8001);
    do_op("lhu",   LHU, 32'h100, 32'h0,         1, 0, 32'h8001F234, 32'h100, 4'h3, 32'h0,        32'h0000F234);
    do_op("lb1",   LB,  32'h101, 32'h0,         0, 1, 32'h00007F00, 32'h100, 4'h2, 32'h0,        32'h0000007F);
    do_op("sb",    SB,  32'h105, 32'h000000A5,  0, 0, 32'h0,        32'h104, 4'h2, 32'h0000A500, 32'h0);
    do_op("sw",    SW,  32'h108, 32'hCAFEF00D,  1, 0, 32'h0,        32'h108, 4'hF, 32'hCAFEF00D, 32'h0);

    // Stray rvalid while idle must not disturb the held load result.
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'hFFFFFFFF;
    tick();
    bus.data_rvalid_i = 1'b0;
    tick();
    check("stray_rvalid_hold", load_data, last_load);
    check("stray_rvalid_busy", {31'b0, busy}, 32'h0);

    do_misal("lh_mis",  LH,  32'h103);
    do_misal("sh_mis",  SH,  32'h101);
    do_misal("sw_mis",  SW,  32'h10A);
    do_misal("lhu_mis", LHU, 32'h101);
    do_op("lw_slow", LW,  32'h10C, 32'h0,       2, 2, 32'h0BADF00D, 32'h10C, 4'hF, 32'h0,        32'h0BADF00D);
    do_op("lb_neg",  LB,  32'h106, 32'h0,       0, 0, 32'h00F00000, 32'h104, 4'h4, 32'h0,        32'hFFFFFFF0);

    // Reset while waiting for rvalid: everything clears immediately, no pulse.
    beat_q.push_back('{32'h300, 1'b0, 4'hF, 32'h0, "lw_rst"});
    en = 1'b1; valid = 1'b1; op = LW; addr = 32'h300;
    tick();
    en = 1'b0; valid = 1'b0;
    bus.data_gnt_i = 1'b1;
    tick();
    bus.data_gnt_i = 1'b0;
    check("lw_rst_busy_before", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("lw_rst_req",    {31'b0, bus.data_req_op}, 32'h0);
    check("lw_rst_busy",   {31'b0, busy}, 32'h0);
    check("lw_rst_ldata",  load_data, 32'h0);
    check("lw_rst_rvalid", {31'b0, rvalid}, 32'h0);
    tick();
    rst_n = 1'b1;
    last_load = 32'h0;
    tick();
    do_op("lw_after_rst", LW, 32'h304, 32'h0, 0, 0, 32'h12345678, 32'h304, 4'hF, 32'h0, 32'h12345678);

    // Grant never arrives.
`ifdef LSU_TIMEOUT_EN
    resp_q.push_back('{3'b100, 1'b0, 32'h0, "lw_timeout"});
    en = 1'b1; valid = 1'b1; op = LW; addr = 32'h200;
    tick();
    en = 1'b0; valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check("lw_timeout_req_held", {31'b0, bus.data_req_op}, 32'h1);
      tick();
    end
    check("lw_timeout_busy", {31'b0, busy}, 32'h0);
    check("lw_timeout_req",  {31'b0, bus.data_req_op}, 32'h0);
    tick();
`else
    en = 1'b1; valid = 1'b1; op = LW; addr = 32'h200;
    tick();
    en = 1'b0; valid = 1'b0;
    repeat (20) tick();
    check("lw_nogrant_busy", {31'b0, busy}, 32'h1);
    check("lw_nogrant_req",  {31'b0, bus.data_req_op}, 32'h1);
    check("lw_nogrant_tmo",  {31'b0, tmo}, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif

    repeat (3) tick();
    check("resp_queue_drained", resp_q.size(), 32'h0);
    check("beat_queue_drained", beat_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
